layer_compositor: RTL and testbench
===================================

# layer_compositor

Parametrised N-layer priority compositor with per-game-state layer masks, frame-synchronous fade-to-black on game-state change, and per-frame collision reporting. It sits between the object drawers (player, aliens, shots, terrain, screens) and the VGA output stage. It replaces fixed per-state priority chains with a runtime-writable mask table. Output is a registered 12-bit-style RGB triple, 2 cycles after the pixel inputs.

## Interface
- N_LAYERS, 8: number of drawable layers; index 0 is highest priority and is the collision reference (player).
- COLOR_W, 4: bits per colour channel.
- BG_STATE_MASK, 8'b0000_0100: bit s set means background_rgb fills undrawn pixels in state s; otherwise undrawn pixels are black.
- FADE_EN, 1: 0 disables fading; shown state follows game_state with 1 cycle of delay.
- FRAMES_PER_STEP, 1: startOfFrame pulses per fade level step (1..15).

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- game_state  in  3  current game state
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
- layer_dr  in  N_LAYERS  per-layer draw request
- layer_rgb  in  N_LAYERS*3*COLOR_W  packed RGB; layer i occupies bits [i*3*COLOR_W +: 3*COLOR_W], with R in the MSBs
- background_rgb  in  3*COLOR_W  background colour
- mask_wr  in  1  mask table write strobe
- mask_state  in  3  mask table entry to write
- mask_data  in  N_LAYERS  enable bits for that entry
- Red_level, Green_level, Blue_level  out  COLOR_W each  composited pixel
- hit_vector  out  N_LAYERS  collisions from the previous frame; bit 0 is always 0
- hit_valid  out  1  one-cycle pulse when hit_vector updates
- fade_busy  out  1  high while not in IDLE

## Operation
- **Mask table.** The table holds 8 entries of N_LAYERS bits. Reset value is all ones in every entry. A write takes effect on the next cycle. A read in the same cycle as a write to that entry returns the old value.
- **Shown state.** The compositor draws using shown_state, not game_state directly.
- **Stage 1 (registered).**
  - eff = layer_dr & mask[shown_state].
  - Priority-encode the lowest set bit of eff and register the selected RGB.
  - If eff is 0: register background_rgb if BG_STATE_MASK[shown_state] is set, else 0.
- **Stage 2 (registered).**
  - Each channel out = (c * L) >> 4, where L is the 5-bit fade level in the range 0..16.
  - L = 16 is exact identity; L = 0 is black.
  - The product is COLOR_W+5 bits wide, truncated back to COLOR_W.
- **Fade FSM** (a step is FRAMES_PER_STEP startOfFrame pulses, counted by a frame counter that clears on every state transition):
  - IDLE: L = 16. When game_state != shown_state, go to FADE_OUT.
  - FADE_OUT: decrement L by 1 per step. On reaching L = 0, load shown_state = game_state (the latest value) and go to FADE_IN.
  - FADE_IN: increment L by 1 per step. On reaching 16, go to IDLE.
  - A game_state change during FADE_OUT stays in FADE_OUT; the new target is picked up at L = 0.
  - If game_state differs from shown_state during FADE_IN, go to FADE_OUT from the current L.
  - With FADE_EN = 0: the FSM is held in IDLE, L = 16, and shown_state <= game_state every cycle.
- **Init.** On the first clock after reset release, shown_state <= game_state with no fade.
- **Collisions.**
  - The accumulator ORs in eff[i] & eff[0] for i >= 1 each cycle.
  - On startOfFrame: hit_vector <= accumulator, hit_valid pulses, and the accumulator restarts with the current cycle's hits only. A pixel coincident with startOfFrame belongs to the new frame.

## Timing
- Pixel inputs at cycle t appear on Red/Green/Blue_level at t+2.
- mask and shown_state are sampled in stage 1 (cycle t). L is sampled in stage 2 (cycle t+1).
- hit_vector and hit_valid are valid in the cycle after the startOfFrame edge.
- fade_busy is registered and equals (state != IDLE).
- Reset values:
  - RGB outputs 0, hit_vector 0, hit_valid 0, fade_busy 0.
  - L = 16, state IDLE, frame counter 0, shown_state 0, accumulator 0, mask all ones.
- If reset is asserted mid-fade, all of the above return to reset values immediately, and init behaviour applies after release.
- A fade at FRAMES_PER_STEP = 1 takes 16 frames out plus 16 frames in.

## Test plan
- **Priority.** N_LAYERS = 8, all masks ones, layer_dr = 8'b0010_0100, layer 2 = 12'hF00, layer 5 = 12'h0F0 -> output 12'hF00 two cycles later. With mask[shown] = 8'b1111_1011, the output becomes 12'h0F0.
- **Background select.** State 2, layer_dr = 0, background_rgb = 12'h123 -> 12'h123. Same in state 1 -> 12'h000.
- **Fade.** Settle in state 1, switch to state 2, and feed constant 12'hFFF:
  - fade_busy rises.
  - After 8 startOfFrame pulses, L = 8 and output = 12'h777.
  - At L = 0, output = 0 and shown_state = 2.
  - After 16 more pulses, output = 12'hFFF and fade_busy = 0.
- **Mid-fade changes.**
  - Go 1 -> 2, then to 4 at L = 10 during FADE_OUT -> fade continues; shown_state = 4 at L = 0.
  - During FADE_IN at L = 6, change state -> L decrements from 6.
- **Collisions.** In one frame assert eff bits {0,3} on one pixel and {0,5} on another; assert {3} alone elsewhere -> at the next startOfFrame, hit_vector = 8'b0010_1000 and hit_valid pulses once. A hit on the startOfFrame cycle appears only in the following frame's report.
- **Mask write / reset.** Write a mask in the same cycle the entry is used -> the old mask applies that pixel and the new mask applies the next. Assert resetN low mid-FADE_IN -> all outputs 0 and L = 16. After release, shown_state equals game_state with no fade.

Source files
------------

// File: rtl/layer_compositor.sv
// layer_compositor: N-layer priority compositor placed between the object drawers and the VGA output stage.
// Features: a runtime-writable per-game-state layer mask table, a frame-synchronous
// fade-to-black when the game state changes, and per-frame collision reporting.
// Ports:
//   clk, resetN                pixel clock, asynchronous active-low reset
//   game_state, startOfFrame   requested game state, first-pixel-of-frame pulse
//   layer_dr, layer_rgb        per-layer draw request and packed RGB (layer 0 = highest priority)
//   background_rgb             fill colour for undrawn pixels in BG_STATE_MASK states
//   mask_wr/state/data         mask table write port
//   Red/Green/Blue_level       composited pixel, 2 cycles after the pixel inputs
//   hit_vector, hit_valid      previous-frame collisions against layer 0, update pulse
//   fade_busy                  high while a fade is in progress
module layer_compositor #(
  parameter int unsigned N_LAYERS        = 8,
  parameter int unsigned COLOR_W         = 4,
  parameter logic [7:0]  BG_STATE_MASK   = 8'b0000_0100,
  parameter bit          FADE_EN         = 1'b1,
  parameter int unsigned FRAMES_PER_STEP = 1
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic [2:0]                      game_state,
  input  logic                            startOfFrame,
  input  logic [N_LAYERS-1:0]             layer_dr,
  input  logic [N_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic [3*COLOR_W-1:0]            background_rgb,
  input  logic                            mask_wr,
  input  logic [2:0]                      mask_state,
  input  logic [N_LAYERS-1:0]             mask_data,
  output logic [COLOR_W-1:0]              Red_level,
  output logic [COLOR_W-1:0]              Green_level,
  output logic [COLOR_W-1:0]              Blue_level,
  output logic [N_LAYERS-1:0]             hit_vector,
  output logic                            hit_valid,
  output logic                            fade_busy
);

  localparam int unsigned RGB_W  = 3 * COLOR_W;
  localparam int unsigned PROD_W = COLOR_W + 5;
  localparam int unsigned LVL_W  = 5;
  localparam int unsigned CNT_W  = 4;
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(16);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FADE_OUT, ST_FADE_IN} fade_state_e;

  fade_state_e          state_q, state_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [2:0]           shown_q, shown_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                 init_q;
  logic [N_LAYERS-1:0]  mask_q [8];
  logic [N_LAYERS-1:0]  acc_q;
  logic [RGB_W-1:0]     pix_q;

  logic [N_LAYERS-1:0]  eff_c;
  logic [N_LAYERS-1:0]  hits_c;
  logic [RGB_W-1:0]     pix_c;
  logic                 step_c;

  // Channel scaling by the fade level: L=16 is identity, L=0 is black.
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [LVL_W-1:0]   l);
    logic [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(l);
    return COLOR_W'(p >> 4);
  endfunction

  assign eff_c  = layer_dr & mask_q[shown_q];
  // Layer 0 is the collision reference, so bit 0 never reports.
  assign hits_c = {eff_c[N_LAYERS-1:1] & {(N_LAYERS-1){eff_c[0]}}, 1'b0};
  assign step_c = startOfFrame && (frame_cnt_q == CNT_LAST);

  // Lowest-index enabled layer wins; otherwise background or black.
  always_comb begin
    pix_c = BG_STATE_MASK[shown_q] ? background_rgb : '0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (eff_c[i]) pix_c = layer_rgb[i*RGB_W +: RGB_W];
    end
  end

  // Fade sequencing and shown-state selection.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    shown_d     = shown_q;
    frame_cnt_d = frame_cnt_q;
    if (startOfFrame) frame_cnt_d = step_c ? '0 : frame_cnt_q + CNT_W'(1);
    if (!init_q) begin
      // First clock after reset adopts the requested state without fading.
      shown_d = game_state;
    end else if (!FADE_EN) begin
      state_d     = ST_IDLE;
      level_d     = LVL_MAX;
      shown_d     = game_state;
      frame_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          level_d = LVL_MAX;
          if (game_state != shown_q) begin
            state_d     = ST_FADE_OUT;
            frame_cnt_d = '0;
          end
        end
        ST_FADE_OUT: begin
          // A retarget from FADE_IN can arrive here already at black.
          if (level_q == '0) begin
            shown_d     = game_state;
            state_d     = ST_FADE_IN;
            frame_cnt_d = '0;
          end else if (step_c) begin
            level_d = level_q - LVL_W'(1);
            if (level_q == LVL_W'(1)) begin
              shown_d     = game_state;
              state_d     = ST_FADE_IN;
              frame_cnt_d = '0;
            end
          end
        end
        ST_FADE_IN: begin
          if (game_state != shown_q) begin
            state_d     = ST_FADE_OUT;
            frame_cnt_d = '0;
          end else if (step_c) begin
            level_d = level_q + LVL_W'(1);
            if (level_q == LVL_W'(15)) begin
              state_d     = ST_IDLE;
              frame_cnt_d = '0;
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          level_d     = LVL_MAX;
          frame_cnt_d = '0;
        end
      endcase
    end
  end

  // Fade state registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      level_q     <= LVL_MAX;
      shown_q     <= 3'd0;
      frame_cnt_q <= '0;
      init_q      <= 1'b0;
      fade_busy   <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      shown_q     <= shown_d;
      frame_cnt_q <= frame_cnt_d;
      init_q      <= 1'b1;
      fade_busy   <= (state_d != ST_IDLE);
    end
  end

  // Mask table, two-stage pixel pipeline and collision accumulator.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int s = 0; s < 8; s++) mask_q[s] <= '1;
      pix_q       <= '0;
      Red_level   <= '0;
      Green_level <= '0;
      Blue_level  <= '0;
      acc_q       <= '0;
      hit_vector  <= '0;
      hit_valid   <= 1'b0;
    end else begin
      if (mask_wr) mask_q[mask_state] <= mask_data;
      pix_q       <= pix_c;
      Red_level   <= scale(pix_q[RGB_W-1 -: COLOR_W], level_q);
      Green_level <= scale(pix_q[2*COLOR_W-1 -: COLOR_W], level_q);
      Blue_level  <= scale(pix_q[COLOR_W-1:0], level_q);
      hit_valid   <= startOfFrame;
      if (startOfFrame) begin
        // The startOfFrame pixel belongs to the new frame.
        hit_vector <= acc_q;
        acc_q      <= hits_c;
      end else begin
        acc_q <= acc_q | hits_c;
      end
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Testbench for layer_compositor: scenario tasks plus a randomized pixel stream
// checked against a behavioural compositing model.
module tb_layer_compositor;

  localparam logic [7:0] BG_MASK = 8'b0000_0100;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic [2:0]  game_state = 3'd0;
  logic        startOfFrame = 1'b0;
  logic [7:0]  layer_dr = 8'h00;
  logic [95:0] layer_rgb = '0;
  logic [11:0] background_rgb = 12'h000;
  logic        mask_wr = 1'b0;
  logic [2:0]  mask_state = 3'd0;
  logic [7:0]  mask_data = 8'hFF;
  logic [3:0]  Red_level, Green_level, Blue_level;
  logic [7:0]  hit_vector;
  logic        hit_valid, fade_busy;

  int checks = 0;
  int errors = 0;

  layer_compositor dut (
    .clk(clk), .resetN(resetN), .game_state(game_state), .startOfFrame(startOfFrame),
    .layer_dr(layer_dr), .layer_rgb(layer_rgb), .background_rgb(background_rgb),
    .mask_wr(mask_wr), .mask_state(mask_state), .mask_data(mask_data),
    .Red_level(Red_level), .Green_level(Green_level), .Blue_level(Blue_level),
    .hit_vector(hit_vector), .hit_valid(hit_valid), .fade_busy(fade_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] scale_rgb(input logic [11:0] c, input int l);
    int r, g, b;
    r = (int'(c[11:8]) * l) / 16;
    g = (int'(c[7:4]) * l) / 16;
    b = (int'(c[3:0]) * l) / 16;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  function automatic logic [11:0] compose(input logic [7:0] dr, input logic [95:0] rgb,
                                          input logic [7:0] m, input logic [11:0] bg, input int st);
    logic [7:0] eff;
    eff = dr & m;
    for (int i = 0; i < 8; i++) if (eff[i]) return rgb[i*12 +: 12];
    return BG_MASK[st] ? bg : 12'h000;
  endfunction

  function automatic logic [11:0] out_rgb();
    return {Red_level, Green_level, Blue_level};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] gs);
    resetN = 1'b0; game_state = gs; startOfFrame = 1'b0; mask_wr = 1'b0; layer_dr = 8'h00;
    tick(); tick();
    resetN = 1'b1;
    tick(); tick();
  endtask

  task automatic pulse_sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (out_rgb() !== 12'h000 || hit_vector !== 8'h00 || hit_valid !== 1'b0 || fade_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got rgb=%h hv=%h hvld=%b busy=%b want all 0",
               out_rgb(), hit_vector, hit_valid, fade_busy);
    end
    tick(); tick();
    game_state = 3'd1;
    resetN = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (fade_busy !== 1'b0) begin
      errors++; $display("FAIL init_no_fade got busy=%b want 0", fade_busy);
    end
  endtask

  task automatic test_background();
    layer_dr = 8'h00; background_rgb = 12'h123;
    tick(); tick();
    checks++;
    if (out_rgb() !== 12'h000) begin
      errors++; $display("FAIL bg_state1 got %h want 000", out_rgb());
    end
    do_reset(3'd2);
    background_rgb = 12'h123;
    tick(); tick();
    checks++;
    if (out_rgb() !== 12'h123) begin
      errors++; $display("FAIL bg_state2 got %h want 123", out_rgb());
    end
  endtask

  task automatic test_priority();
    layer_rgb = '0;
    layer_rgb[2*12 +: 12] = 12'hF00;
    layer_rgb[5*12 +: 12] = 12'h0F0;
    layer_dr = 8'b0010_0100;
    tick(); tick();
    checks++;
    if (out_rgb() !== 12'hF00) begin
      errors++; $display("FAIL priority_all_ones got %h want F00", out_rgb());
    end
    mask_wr = 1'b1; mask_state = 3'd2; mask_data = 8'b1111_1011;
    tick();
    mask_wr = 1'b0;
    tick(); tick();
    checks++;
    if (out_rgb() !== 12'h0F0) begin
      errors++; $display("FAIL priority_masked got %h want 0F0", out_rgb());
    end
    mask_wr = 1'b1; mask_data = 8'hFF;
    tick();
    mask_wr = 1'b0;
    tick(); tick();
    checks++;
    if (out_rgb() !== 12'hF00) begin
      errors++; $display("FAIL priority_restored got %h want F00", out_rgb());
    end
  endtask

  task automatic test_mask_same_cycle();
    mask_wr = 1'b1; mask_state = 3'd2; mask_data = 8'b1111_1011;
    tick();
    mask_wr = 1'b0;
    tick();
    checks++;
    if (out_rgb() !== 12'hF00) begin
      errors++; $display("FAIL mask_old_same_cycle got %h want F00", out_rgb());
    end
    tick();
    checks++;
    if (out_rgb() !== 12'h0F0) begin
      errors++; $display("FAIL mask_new_next_cycle got %h want 0F0", out_rgb());
    end
    mask_wr = 1'b1; mask_data = 8'hFF;
    tick();
    mask_wr = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0]  mm [8];
    logic [7:0]  acc, last_rep, exp_rep, eff, hits;
    logic [11:0] e, prev_e;
    logic        sof, wr;
    logic [2:0]  ms;
    logic [7:0]  md;
    for (int s = 0; s < 8; s++) mm[s] = 8'hFF;
    layer_dr = 8'h00; startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    acc = 8'h00; last_rep = 8'h00; prev_e = 12'h000; exp_rep = 8'h00;
    for (int i = 0; i < 400; i++) begin
      sof = ($urandom_range(0, 15) == 0);
      wr  = ($urandom_range(0, 3) == 0);
      ms  = 3'($urandom_range(0, 7));
      md  = 8'($urandom);
      layer_dr = 8'($urandom) | 8'($urandom_range(0, 1));
      for (int j = 0; j < 3; j++) layer_rgb[j*32 +: 32] = $urandom;
      background_rgb = 12'($urandom);
      startOfFrame = sof; mask_wr = wr; mask_state = ms; mask_data = md;
      e = compose(layer_dr, layer_rgb, mm[2], background_rgb, 2);
      eff = layer_dr & mm[2];
      hits = 8'h00;
      for (int j = 1; j < 8; j++) hits[j] = eff[j] & eff[0];
      if (sof) begin exp_rep = acc; acc = hits; end
      else acc = acc | hits;
      if (wr) mm[ms] = md;
      tick();
      if (i > 0) begin
        checks++;
        if (out_rgb() !== prev_e) begin
          errors++; $display("FAIL random_pixel %0d got %h want %h", i - 1, out_rgb(), prev_e);
        end
      end
      if (sof) last_rep = exp_rep;
      checks++;
      if (hit_valid !== sof || hit_vector !== last_rep) begin
        errors++;
        $display("FAIL random_hits %0d got vld=%b vec=%h want vld=%b vec=%h",
                 i, hit_valid, hit_vector, sof, last_rep);
      end
      prev_e = e;
    end
    startOfFrame = 1'b0; mask_wr = 1'b0;
    tick();
    checks++;
    if (out_rgb() !== prev_e) begin
      errors++; $display("FAIL random_pixel_last got %h want %h", out_rgb(), prev_e);
    end
    for (int s = 0; s < 8; s++) begin
      mask_wr = 1'b1; mask_state = 3'(s); mask_data = 8'hFF;
      tick();
    end
    mask_wr = 1'b0;
  endtask

  task automatic test_fade();
    int lvl;
    do_reset(3'd1);
    layer_rgb = '0;
    layer_rgb[11:0] = 12'hFFF;
    layer_dr = 8'h01;
    tick(); tick();
    checks++;
    if (out_rgb() !== 12'hFFF || fade_busy !== 1'b0) begin
      errors++; $display("FAIL fade_settled got %h busy=%b want FFF busy=0", out_rgb(), fade_busy);
    end
    game_state = 3'd2;
    tick(); tick();
    checks++;
    if (fade_busy !== 1'b1) begin
      errors++; $display("FAIL fade_busy_rise got %b want 1", fade_busy);
    end
    lvl = 16;
    for (int k = 0; k < 16; k++) begin
      pulse_sof();
      lvl--;
      checks++;
      if (out_rgb() !== scale_rgb(12'hFFF, lvl)) begin
        errors++; $display("FAIL fade_out L=%0d got %h want %h", lvl, out_rgb(), scale_rgb(12'hFFF, lvl));
      end
      if (lvl == 8) begin
        checks++;
        if (out_rgb() !== 12'h777) begin
          errors++; $display("FAIL fade_half got %h want 777", out_rgb());
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      pulse_sof();
      lvl++;
      checks++;
      if (out_rgb() !== scale_rgb(12'hFFF, lvl)) begin
        errors++; $display("FAIL fade_in L=%0d got %h want %h", lvl, out_rgb(), scale_rgb(12'hFFF, lvl));
      end
    end
    checks++;
    if (out_rgb() !== 12'hFFF || fade_busy !== 1'b0) begin
      errors++; $display("FAIL fade_done got %h busy=%b want FFF busy=0", out_rgb(), fade_busy);
    end
    layer_dr = 8'h00; background_rgb = 12'h123;
    tick(); tick();
    checks++;
    if (out_rgb() !== 12'h123) begin
      errors++; $display("FAIL fade_shown_state got %h want 123", out_rgb());
    end
  endtask

  task automatic test_mid_fade();
    int lvl;
    do_reset(3'd1);
    layer_rgb = '0;
    layer_rgb[11:0] = 12'hFFF;
    layer_dr = 8'h01;
    game_state = 3'd2;
    tick(); tick();
    lvl = 16;
    for (int k = 0; k < 6; k++) begin pulse_sof(); lvl--; end
    checks++;
    if (out_rgb() !== scale_rgb(12'hFFF, 10)) begin
      errors++; $display("FAIL mid_L10 got %h want %h", out_rgb(), scale_rgb(12'hFFF, 10));
    end
    game_state = 3'd4;
    for (int k = 0; k < 10; k++) begin
      pulse_sof();
      lvl--;
      checks++;
      if (out_rgb() !== scale_rgb(12'hFFF, lvl)) begin
        errors++; $display("FAIL mid_retarget_out L=%0d got %h want %h", lvl, out_rgb(), scale_rgb(12'hFFF, lvl));
      end
    end
    for (int k = 0; k < 6; k++) begin pulse_sof(); lvl++; end
    checks++;
    if (out_rgb() !== scale_rgb(12'hFFF, 6) || fade_busy !== 1'b1) begin
      errors++; $display("FAIL mid_in_L6 got %h busy=%b want %h busy=1", out_rgb(), fade_busy, scale_rgb(12'hFFF, 6));
    end
    layer_dr = 8'h00; background_rgb = 12'hFFF;
    tick(); tick();
    checks++;
    if (out_rgb() !== 12'h000) begin
      errors++; $display("FAIL mid_shown_is_4 got %h want 000", out_rgb());
    end
    layer_dr = 8'h01;
    game_state = 3'd2;
    tick(); tick();
    checks++;
    if (out_rgb() !== scale_rgb(12'hFFF, 6) || fade_busy !== 1'b1) begin
      errors++; $display("FAIL mid_reverse_hold got %h busy=%b want %h busy=1", out_rgb(), fade_busy, scale_rgb(12'hFFF, 6));
    end
    for (int k = 0; k < 6; k++) begin
      pulse_sof();
      lvl--;
      checks++;
      if (out_rgb() !== scale_rgb(12'hFFF, lvl)) begin
        errors++; $display("FAIL mid_reverse_out L=%0d got %h want %h", lvl, out_rgb(), scale_rgb(12'hFFF, lvl));
      end
    end
    for (int k = 0; k < 3; k++) begin pulse_sof(); lvl++; end
    checks++;
    if (out_rgb() !== scale_rgb(12'hFFF, 3)) begin
      errors++; $display("FAIL mid_second_in L=3 got %h want %h", out_rgb(), scale_rgb(12'hFFF, 3));
    end
  endtask

  task automatic test_reset_mid_fade();
    game_state = 3'd4;
    resetN = 1'b0;
    #1;
    checks++;
    if (out_rgb() !== 12'h000 || hit_vector !== 8'h00 || hit_valid !== 1'b0 || fade_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fade got rgb=%h hv=%h hvld=%b busy=%b want all 0",
               out_rgb(), hit_vector, hit_valid, fade_busy);
    end
    tick(); tick();
    resetN = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (out_rgb() !== 12'hFFF) begin
      errors++; $display("FAIL reset_release_L16 got %h want FFF", out_rgb());
    end
    for (int k = 0; k < 3; k++) begin
      pulse_sof();
      checks++;
      if (fade_busy !== 1'b0 || out_rgb() !== 12'hFFF) begin
        errors++; $display("FAIL reset_release_no_fade got busy=%b rgb=%h want 0 FFF", fade_busy, out_rgb());
      end
    end
    layer_dr = 8'h00; background_rgb = 12'h123;
    tick(); tick();
    checks++;
    if (out_rgb() !== 12'h000) begin
      errors++; $display("FAIL reset_release_shown got %h want 000", out_rgb());
    end
  endtask

  task automatic test_collisions();
    int pulses;
    layer_dr = 8'h00; startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    layer_dr = 8'b0000_1001; tick();
    layer_dr = 8'b0010_0001; tick();
    layer_dr = 8'b0000_1000; tick();
    layer_dr = 8'h00;        tick();
    layer_dr = 8'b0100_0001; startOfFrame = 1'b1;
    tick();
    checks++;
    if (hit_valid !== 1'b1 || hit_vector !== 8'b0010_1000) begin
      errors++; $display("FAIL collision_report got vld=%b vec=%b want 1 00101000", hit_valid, hit_vector);
    end
    layer_dr = 8'h00; startOfFrame = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (hit_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || hit_vector !== 8'b0010_1000) begin
      errors++; $display("FAIL collision_single_pulse got extra=%0d vec=%b want 0 00101000", pulses, hit_vector);
    end
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    checks++;
    if (hit_valid !== 1'b1 || hit_vector !== 8'b0100_0000) begin
      errors++; $display("FAIL collision_sof_pixel got vld=%b vec=%b want 1 01000000", hit_valid, hit_vector);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_background();
    test_priority();
    test_mask_same_cycle();
    test_random();
    test_fade();
    test_mid_fade();
    test_reset_mid_fade();
    test_collisions();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
